// File: rtl/music_player_ctrl_if.sv
// Control/status bundle between the button front-end, the playback controller
// and the note player / song ROM.
interface music_player_ctrl_if #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
);
  logic                           play_button;
  logic                           next_button;
  logic                           prev_button;
  logic                           ff_switch;
  logic                           r_switch;
  logic                           note_done;
  logic                           play;
  logic                           beat;
  logic [SONG_BITS-1:0]           current_song;
  logic [SONG_BITS+NOTE_BITS-1:0] note_addr;
  logic                           flush;
  logic                           song_end;

  modport master (
    output play_button, next_button, prev_button, ff_switch, r_switch, note_done,
    input  play, beat, current_song, note_addr, flush, song_end
  );

  modport slave (
    input  play_button, next_button, prev_button, ff_switch, r_switch, note_done,
    output play, beat, current_song, note_addr, flush, song_end
  );
endinterface

// File: rtl/music_player_ctrl.sv
// Playback controller: play/pause FSM, song selection, beat generator and
// note address into the song ROM, with prev, fast-forward, rewind, auto-advance.
module music_player_ctrl #(
  parameter int SONG_BITS    = 2,
  parameter int NOTE_BITS    = 5,
  parameter int BEAT_COUNT   = 1000,
  parameter int FF_MULT      = 2,
  parameter bit AUTO_ADVANCE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  music_player_ctrl_if.slave bus
);

  // Wide enough for beat_cnt + step, which can overshoot BEAT_COUNT by < FF_MULT.
  localparam int CNT_W = $clog2(BEAT_COUNT + FF_MULT + 1);
  localparam logic [NOTE_BITS-1:0] LAST_IDX = {NOTE_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_SWITCH  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [NOTE_BITS-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 beat_q, beat_d;
  logic                 flush_q, flush_d;
  logic                 song_end_q, song_end_d;

  logic                 song_chg;
  logic                 rewind;
  logic [CNT_W-1:0]     step;
  logic [CNT_W-1:0]     cnt_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_PAUSED;
      song_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      beat_q     <= 1'b0;
      flush_q    <= 1'b0;
      song_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      flush_q    <= flush_d;
      song_end_q <= song_end_d;
    end
  end

  // Both switches high counts as rewind at normal speed.
  assign rewind   = bus.r_switch;
  assign step     = (bus.ff_switch && !bus.r_switch) ? CNT_W'(FF_MULT) : CNT_W'(1);
  assign cnt_sum  = cnt_q + step;
  assign song_chg = bus.next_button ^ bus.prev_button;

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    beat_d     = 1'b0;
    flush_d    = 1'b0;
    song_end_d = 1'b0;

    if (song_chg) begin
      // Song change overrides play_button and note_done in every state.
      state_d = ST_SWITCH;
      song_d  = bus.next_button ? song_q + SONG_BITS'(1) : song_q - SONG_BITS'(1);
      idx_d   = '0;
      cnt_d   = '0;
      flush_d = 1'b1;
    end else begin
      case (state_q)
        ST_PAUSED: begin
          if (bus.play_button) begin
            state_d = ST_PLAYING;
          end
        end
        ST_SWITCH: begin
          state_d = ST_PAUSED;
        end
        ST_PLAYING: begin
          if (bus.note_done) begin
            if (rewind) begin
              if (idx_q == '0) begin
                song_end_d = 1'b1;
                state_d    = ST_PAUSED;
              end else begin
                idx_d = idx_q - NOTE_BITS'(1);
              end
            end else if (idx_q == LAST_IDX) begin
              song_end_d = 1'b1;
              idx_d      = '0;
              if (AUTO_ADVANCE) begin
                song_d  = song_q + SONG_BITS'(1);
                flush_d = 1'b1;
              end else begin
                state_d = ST_PAUSED;
              end
            end else begin
              idx_d = idx_q + NOTE_BITS'(1);
            end
          end
          // Note advance above still applies when pausing in the same cycle.
          if (bus.play_button) begin
            state_d = ST_PAUSED;
          end
          // Beat phase only moves while staying in PLAYING, so no beat after a pause.
          if (state_d == ST_PLAYING) begin
            if (cnt_sum >= CNT_W'(BEAT_COUNT)) begin
              beat_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_sum;
            end
          end
        end
        default: begin
          state_d = ST_PAUSED;
        end
      endcase
    end

    // Held buttons or back-to-back note_done must not stretch the pulses.
    flush_d    = flush_d & ~flush_q;
    song_end_d = song_end_d & ~song_end_q;
  end

  assign bus.play         = (state_q == ST_PLAYING);
  assign bus.beat         = beat_q;
  assign bus.current_song = song_q;
  assign bus.note_addr    = {song_q, idx_q};
  assign bus.flush        = flush_q;
  assign bus.song_end     = song_end_q;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Directed bench for music_player_ctrl: two instances (auto-advance on/off)
// share one stimulus stream; NOTE_BITS=2, BEAT_COUNT=100, FF_MULT=2.
module tb_music_player_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  music_player_ctrl_if #(.SONG_BITS(2), .NOTE_BITS(2)) bus_a ();
  music_player_ctrl_if #(.SONG_BITS(2), .NOTE_BITS(2)) bus_b ();

  assign bus_b.play_button = bus_a.play_button;
  assign bus_b.next_button = bus_a.next_button;
  assign bus_b.prev_button = bus_a.prev_button;
  assign bus_b.ff_switch   = bus_a.ff_switch;
  assign bus_b.r_switch    = bus_a.r_switch;
  assign bus_b.note_done   = bus_a.note_done;

  music_player_ctrl #(.SONG_BITS(2), .NOTE_BITS(2), .BEAT_COUNT(100), .FF_MULT(2),
                      .AUTO_ADVANCE(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  music_player_ctrl #(.SONG_BITS(2), .NOTE_BITS(2), .BEAT_COUNT(100), .FF_MULT(2),
                      .AUTO_ADVANCE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus_a.play_button = 1'b0;
    bus_a.next_button = 1'b0;
    bus_a.prev_button = 1'b0;
    bus_a.ff_switch   = 1'b0;
    bus_a.r_switch    = 1'b0;
    bus_a.note_done   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic pulse_play();
    bus_a.play_button = 1'b1; tick(1); bus_a.play_button = 1'b0;
  endtask
  task automatic pulse_next();
    bus_a.next_button = 1'b1; tick(1); bus_a.next_button = 1'b0;
  endtask
  task automatic pulse_prev();
    bus_a.prev_button = 1'b1; tick(1); bus_a.prev_button = 1'b0;
  endtask
  task automatic pulse_note();
    bus_a.note_done = 1'b1; tick(1); bus_a.note_done = 1'b0;
  endtask

  // Clock edges until the next beat; 0 if none within 300 cycles.
  task automatic wait_beat(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      tick(1);
      if (bus_a.beat === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({bus_a.play, bus_a.beat, bus_a.flush, bus_a.song_end} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got=%b want=0000", {bus_a.play, bus_a.beat, bus_a.flush, bus_a.song_end}); end
    n_cmp++; if (bus_a.current_song !== 2'd0) begin n_bad++; $display("FAIL reset_song got=%0d want=0", bus_a.current_song); end
    n_cmp++; if (bus_a.note_addr !== 4'd0) begin n_bad++; $display("FAIL reset_addr got=%0d want=0", bus_a.note_addr); end
    pulse_next(); tick(1); pulse_next(); tick(1);
    pulse_play(); pulse_note(); pulse_note();
    n_cmp++; if (bus_a.note_addr !== 4'b1010 || bus_a.play !== 1'b1) begin n_bad++; $display("FAIL pre_reset_state addr=%b play=%b want addr=1010 play=1", bus_a.note_addr, bus_a.play); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({bus_a.play, bus_a.beat} !== 2'b00) begin n_bad++; $display("FAIL async_reset_play_beat got=%b want=00", {bus_a.play, bus_a.beat}); end
    n_cmp++; if (bus_a.current_song !== 2'd0 || bus_a.note_addr !== 4'd0) begin n_bad++; $display("FAIL async_reset_song_addr song=%0d addr=%0d want 0/0", bus_a.current_song, bus_a.note_addr); end
    tick(1);
    reset = 1'b1;
    tick(1);
    $display("reset: async clear checked");
  endtask

  task automatic test_beat();
    int n;
    bit saw;
    do_reset();
    pulse_play();
    n_cmp++; if (bus_a.play !== 1'b1) begin n_bad++; $display("FAIL play_latency got=%b want=1", bus_a.play); end
    wait_beat(n);
    n_cmp++; if (n !== 100) begin n_bad++; $display("FAIL beat_first got=%0d want=100", n); end
    wait_beat(n);
    n_cmp++; if (n !== 100) begin n_bad++; $display("FAIL beat_period got=%0d want=100", n); end
    bus_a.ff_switch = 1'b1;
    wait_beat(n);
    n_cmp++; if (n !== 50) begin n_bad++; $display("FAIL beat_ff_period got=%0d want=50", n); end
    bus_a.ff_switch = 1'b0;
    tick(1);
    n_cmp++; if (bus_a.beat !== 1'b0) begin n_bad++; $display("FAIL beat_single_cycle got=%b want=0", bus_a.beat); end
    tick(39);
    pulse_play();
    n_cmp++; if (bus_a.play !== 1'b0) begin n_bad++; $display("FAIL pause got=%b want=0", bus_a.play); end
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus_a.beat !== 1'b0) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL beat_while_paused got=%b want=0", saw); end
    pulse_play();
    wait_beat(n);
    n_cmp++; if (n !== 60) begin n_bad++; $display("FAIL beat_phase_kept got=%0d want=60", n); end
    $display("beat: periods 100/100/50, resume phase checked");
  endtask

  task automatic test_switch();
    do_reset();
    pulse_next(); tick(1); pulse_next(); tick(1); pulse_next(); tick(1);
    n_cmp++; if (bus_a.current_song !== 2'd3) begin n_bad++; $display("FAIL song_three got=%0d want=3", bus_a.current_song); end
    pulse_next();
    n_cmp++; if (bus_a.current_song !== 2'd0 || bus_a.flush !== 1'b1 || bus_a.play !== 1'b0) begin n_bad++; $display("FAIL next_wrap song=%0d flush=%b play=%b want 0/1/0", bus_a.current_song, bus_a.flush, bus_a.play); end
    tick(1);
    n_cmp++; if (bus_a.flush !== 1'b0) begin n_bad++; $display("FAIL flush_one_cycle got=%b want=0", bus_a.flush); end
    pulse_prev();
    n_cmp++; if (bus_a.current_song !== 2'd3 || bus_a.flush !== 1'b1) begin n_bad++; $display("FAIL prev_wrap song=%0d flush=%b want 3/1", bus_a.current_song, bus_a.flush); end
    tick(1);
    pulse_play();
    pulse_next();
    n_cmp++; if (bus_a.current_song !== 2'd0 || bus_a.play !== 1'b0) begin n_bad++; $display("FAIL next_from_playing song=%0d play=%b want 0/0", bus_a.current_song, bus_a.play); end
    $display("switch: next/prev wrap and flush checked");
  endtask

  task automatic test_forward();
    do_reset();
    pulse_play();
    for (int i = 1; i <= 3; i++) begin
      pulse_note();
      n_cmp++; if (bus_a.note_addr !== 4'(i) || bus_a.song_end !== 1'b0) begin n_bad++; $display("FAIL fwd_idx%0d addr=%0d end=%b want %0d/0", i, bus_a.note_addr, bus_a.song_end, i); end
    end
    pulse_note();
    n_cmp++; if (bus_a.song_end !== 1'b1 || bus_a.current_song !== 2'd1 || bus_a.note_addr !== 4'b0100) begin n_bad++; $display("FAIL auto_adv end=%b song=%0d addr=%b want 1/1/0100", bus_a.song_end, bus_a.current_song, bus_a.note_addr); end
    n_cmp++; if (bus_a.play !== 1'b1 || bus_a.flush !== 1'b1) begin n_bad++; $display("FAIL auto_adv_play play=%b flush=%b want 1/1", bus_a.play, bus_a.flush); end
    n_cmp++; if (bus_b.song_end !== 1'b1 || bus_b.play !== 1'b0 || bus_b.note_addr !== 4'd0) begin n_bad++; $display("FAIL no_auto end=%b play=%b addr=%0d want 1/0/0", bus_b.song_end, bus_b.play, bus_b.note_addr); end
    tick(1);
    n_cmp++; if (bus_a.song_end !== 1'b0 || bus_a.flush !== 1'b0) begin n_bad++; $display("FAIL end_pulse_width end=%b flush=%b want 0/0", bus_a.song_end, bus_a.flush); end
    $display("forward: song end with and without auto-advance checked");
  endtask

  task automatic test_rewind();
    do_reset();
    pulse_next(); tick(1);
    pulse_play(); pulse_note(); pulse_note();
    bus_a.r_switch  = 1'b1;
    bus_a.ff_switch = 1'b1;
    pulse_note();
    n_cmp++; if (bus_a.note_addr !== 4'b0101) begin n_bad++; $display("FAIL rew_idx1 got=%b want=0101", bus_a.note_addr); end
    pulse_note();
    n_cmp++; if (bus_a.note_addr !== 4'b0100 || bus_a.song_end !== 1'b0) begin n_bad++; $display("FAIL rew_idx0 addr=%b end=%b want 0100/0", bus_a.note_addr, bus_a.song_end); end
    pulse_note();
    n_cmp++; if (bus_a.song_end !== 1'b1 || bus_a.play !== 1'b0 || bus_a.note_addr !== 4'b0100) begin n_bad++; $display("FAIL rew_end end=%b play=%b addr=%b want 1/0/0100", bus_a.song_end, bus_a.play, bus_a.note_addr); end
    clear_inputs();
    $display("rewind: stops at note 0 of same song checked");
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_a.next_button = 1'b1; bus_a.play_button = 1'b1;
    tick(1);
    clear_inputs();
    n_cmp++; if (bus_a.current_song !== 2'd1 || bus_a.play !== 1'b0 || bus_a.flush !== 1'b1) begin n_bad++; $display("FAIL next_and_play song=%0d play=%b flush=%b want 1/0/1", bus_a.current_song, bus_a.play, bus_a.flush); end
    tick(1);
    bus_a.next_button = 1'b1; bus_a.prev_button = 1'b1;
    tick(1);
    clear_inputs();
    n_cmp++; if (bus_a.current_song !== 2'd1 || bus_a.flush !== 1'b0) begin n_bad++; $display("FAIL next_and_prev song=%0d flush=%b want 1/0", bus_a.current_song, bus_a.flush); end
    pulse_play(); pulse_note();
    bus_a.note_done = 1'b1; bus_a.play_button = 1'b1;
    tick(1);
    clear_inputs();
    n_cmp++; if (bus_a.note_addr !== 4'b0110 || bus_a.play !== 1'b0) begin n_bad++; $display("FAIL note_and_play addr=%b play=%b want 0110/0", bus_a.note_addr, bus_a.play); end
    $display("back_to_back: simultaneous inputs checked");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_beat();
    test_switch();
    test_forward();
    test_rewind();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
